// File: rtl/cpu_bus_arbiter.sv
// Bus arbiter between the tv80s CPU and a secondary requester (DMA / test loader).
// The requester asks for the memory with a level request. The arbiter asks the
// CPU to release the bus with busrq_n and waits for busak_n. It then hands the
// memory mux to the requester. A cooldown period afterwards lets the CPU run
// before the next grant.
module cpu_bus_arbiter #(
    parameter int unsigned MAX_WAIT = 64,
    parameter int unsigned MAX_HOLD = 256,
    parameter int unsigned MIN_CPU  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dma_req,
    output logic       dma_gnt,
    output logic       busrq_n,
    input  logic       busak_n,
    output logic       bus_sel,
    output logic       forced_rel,
    output logic       timeout_err,
    output logic       proto_err,
    output logic [2:0] state
);

    // Keep every counter at least one bit wide, even for degenerate parameters.
    localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned CoolW = (MIN_CPU > 1) ? $clog2(MIN_CPU) : 1;

    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);
    localparam logic [CoolW-1:0] CoolLast = CoolW'(MIN_CPU - 1);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReq      = 3'd1,
        StGrant    = 3'd2,
        StRelease  = 3'd3,
        StCooldown = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CoolW-1:0] cool_cnt_q, cool_cnt_d;
    logic             busrq_n_q, busrq_n_d;
    logic             dma_gnt_q, dma_gnt_d;
    logic             bus_sel_q, bus_sel_d;
    logic             forced_rel_q, forced_rel_d;
    logic             timeout_err_q, timeout_err_d;
    logic             proto_err_q, proto_err_d;

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        cool_cnt_d    = cool_cnt_q;
        forced_rel_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        proto_err_d   = proto_err_q;

        unique case (state_q)
            StIdle: begin
                if (dma_req) begin
                    state_d    = StReq;
                    wait_cnt_d = '0;
                end
            end
            StReq: begin
                // An acknowledge beats both a dropped request and the timeout.
                if (!busak_n) begin
                    state_d    = StGrant;
                    hold_cnt_d = '0;
                end else if (!dma_req) begin
                    state_d = StRelease;
                end else if (wait_cnt_q == WaitLast) begin
                    timeout_err_d = 1'b1;
                    state_d       = StRelease;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StGrant: begin
                // The CPU retaking the bus mid-grant is fatal to the grant: drop the mux at once.
                if (busak_n) begin
                    proto_err_d = 1'b1;
                    state_d     = StCooldown;
                    cool_cnt_d  = '0;
                end else if (!dma_req) begin
                    state_d = StRelease;
                end else if (hold_cnt_q == HoldLast) begin
                    forced_rel_d = 1'b1;
                    state_d      = StRelease;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                // Keep the requester on the mux until the CPU confirms it has the bus back.
                if (busak_n) begin
                    state_d    = StCooldown;
                    cool_cnt_d = '0;
                end
            end
            StCooldown: begin
                if (cool_cnt_q == CoolLast) begin
                    state_d = StIdle;
                end else if (cool_cnt_q != '1) begin
                    cool_cnt_d = cool_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state so that every output is a flop.
    always_comb begin
        busrq_n_d = 1'b1;
        dma_gnt_d = 1'b0;
        bus_sel_d = 1'b0;
        unique case (state_d)
            StReq: begin
                busrq_n_d = 1'b0;
            end
            StGrant: begin
                busrq_n_d = 1'b0;
                dma_gnt_d = 1'b1;
                bus_sel_d = 1'b1;
            end
            StRelease: begin
                bus_sel_d = 1'b1;
            end
            default: begin
                busrq_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            cool_cnt_q    <= '0;
            busrq_n_q     <= 1'b1;
            dma_gnt_q     <= 1'b0;
            bus_sel_q     <= 1'b0;
            forced_rel_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            busrq_n_q     <= busrq_n_d;
            dma_gnt_q     <= dma_gnt_d;
            bus_sel_q     <= bus_sel_d;
            forced_rel_q  <= forced_rel_d;
            timeout_err_q <= timeout_err_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign busrq_n     = busrq_n_q;
    assign dma_gnt     = dma_gnt_q;
    assign bus_sel     = bus_sel_q;
    assign forced_rel  = forced_rel_q;
    assign timeout_err = timeout_err_q;
    assign proto_err   = proto_err_q;
    assign state       = state_q;

endmodule
